// File: rtl/bubble_output_serializer.sv
// -----------------------------------------------------------------------------
// bubble_output_serializer
//
// Purpose:
//   Sits downstream of the bubble timing generator. It prefetches bytes from
//   the page/bootloader buffer over a REQ/ACK read port. Each byte is shifted
//   out LSB-first, one bit per bubble cycle, on the active-low serial bubble
//   data line nBOUT.
//
// Ports:
//   MCLK          in   1   master clock, all logic on posedge
//   RST           in   1   asynchronous active-high reset
//   ACCTYPE       in   3   access type (000 RST, 001 STBY, 100 IDLE, 110 BOOT, 111 USER)
//   BOUTCYCLENUM  in   13  current bit index, INVALID_CYC when no bit is valid
//   BOUTTICKS     in   2   quarter-cycle phase within the bubble cycle
//   MEM_RD_REQ    out  1   byte read request, held until MEM_ACK
//   MEM_ADDR      out  11  byte address, stable while MEM_RD_REQ=1
//   MEM_DIN       in   8   read data, valid while MEM_ACK=1
//   MEM_ACK       in   1   one-cycle read acknowledge
//   nBOUT         out  1   serial bubble data, 0 = bubble present
//   UNDERRUN      out  1   sticky: a byte was needed before its prefetch landed
//   UNDERRUN_CNT  out  8   saturating underrun event count (BOUT_UNDERRUN_CNT_EN only)
//
// Configuration:
//   BOUT_UNDERRUN_CNT_EN  when defined, adds UNDERRUN_CNT. The counter clears
//                         together with UNDERRUN.
// -----------------------------------------------------------------------------
module bubble_output_serializer #(
    parameter logic [10:0] BOOT_BASE   = 11'h400,
    parameter logic [10:0] PAGE_BASE   = 11'h000,
    parameter logic [12:0] INVALID_CYC = 13'h1FFF
) (
    input  logic        MCLK,
    input  logic        RST,
    input  logic [2:0]  ACCTYPE,
    input  logic [12:0] BOUTCYCLENUM,
    input  logic [1:0]  BOUTTICKS,
    output logic        MEM_RD_REQ,
    output logic [10:0] MEM_ADDR,
    input  logic [7:0]  MEM_DIN,
    input  logic        MEM_ACK,
    output logic        nBOUT,
    output logic        UNDERRUN
`ifdef BOUT_UNDERRUN_CNT_EN
    ,
    output logic [7:0]  UNDERRUN_CNT
`endif
);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_FULL} fetch_state_t;

    fetch_state_t state, state_nxt;

    logic [12:0] cyc_q, cyc_prev;
    logic [7:0]  shift_q, prefetch_q;
    logic [9:0]  next_idx;
    logic        pf_valid;
    logic        wrap_pend;   // loop restart: bit 0 waits for the re-fetched byte
    logic        discard_q;   // outstanding read belongs to an abandoned stream

    logic        active, slot_start, restart, byte_slot, wrap_try, wrap_miss;
    logic        load_shift, underrun_evt, ack_drop, ack_take, tick_out;
    logic [10:0] base_addr;

    assign active     = ACCTYPE[1];
    assign base_addr  = ACCTYPE[0] ? PAGE_BASE : BOOT_BASE;
    assign slot_start = (cyc_q != cyc_prev) && (cyc_q != INVALID_CYC);
    // Returning to bit 0 from a valid bit means the boot loop wrapped. The
    // prefetched byte belongs to the old stream position, so it is refetched.
    assign restart    = active && slot_start && (cyc_q == 13'd0) && (cyc_prev != INVALID_CYC);
    assign byte_slot  = active && slot_start && !restart && (cyc_q[2:0] == 3'd0);
    assign wrap_try   = active && !slot_start && wrap_pend;
    // The re-fetched byte is late once the output phase of bit 0 begins.
    assign wrap_miss  = wrap_try && !pf_valid && (BOUTTICKS != 2'b00);
    assign load_shift = byte_slot || (wrap_try && pf_valid);
    assign underrun_evt = (byte_slot && !pf_valid) || wrap_miss;
    assign ack_drop   = discard_q || !active || restart;
    assign ack_take   = (state == F_REQ) && MEM_ACK && !ack_drop;
    assign tick_out   = (BOUTTICKS == 2'b01) || (BOUTTICKS == 2'b10);
    assign MEM_RD_REQ = (state == F_REQ);

    // Fetch FSM: next-state logic
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            F_IDLE:  if (active && !pf_valid && !restart) state_nxt = F_REQ;
            F_REQ:   if (MEM_ACK) state_nxt = ack_drop ? F_IDLE : F_FULL;
            F_FULL:  if (!pf_valid) state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
    end

    // Fetch FSM: state register, request address and abandoned-read tracking
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            // NOTE: non-blocking assignments for all clocked state so every reader sees pre-edge values.
            state     <= F_IDLE;
            MEM_ADDR  <= '0;
            discard_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == F_IDLE && state_nxt == F_REQ)
                MEM_ADDR <= base_addr + {1'b0, next_idx};
            // The request stays up until its ACK even when abandoned. The flag
            // stops the late data being taken if Active returns before the ACK.
            if (state == F_REQ)
                discard_q <= MEM_ACK ? 1'b0 : (discard_q || !active || restart);
        end
    end

    // Bit-slot detection on the registered cycle number
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            cyc_q    <= INVALID_CYC;
            cyc_prev <= INVALID_CYC;
        end else begin
            cyc_q    <= BOUTCYCLENUM;
            cyc_prev <= cyc_q;
        end
    end

    // Prefetch buffer, byte index and shift register
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            shift_q    <= '0;
            prefetch_q <= '0;
            pf_valid   <= 1'b0;
            next_idx   <= '0;
            wrap_pend  <= 1'b0;
        end else if (!active) begin
            pf_valid  <= 1'b0;
            next_idx  <= '0;
            wrap_pend <= 1'b0;
        end else begin
            if (restart) begin
                pf_valid  <= 1'b0;
                next_idx  <= '0;
                wrap_pend <= 1'b1;
            end

            if (load_shift) begin
                shift_q   <= pf_valid ? prefetch_q : 8'h00;
                pf_valid  <= 1'b0;
                wrap_pend <= 1'b0;
            end else if (wrap_miss) begin
                shift_q   <= 8'h00;
                wrap_pend <= 1'b0;
            end else if (slot_start && !restart) begin
                shift_q <= shift_q >> 1;
            end

            // Placed last: a byte landing in a consume cycle becomes the next prefetch.
            if (ack_take) begin
                prefetch_q <= MEM_DIN;
                pf_valid   <= 1'b1;
                next_idx   <= next_idx + 10'd1;
            end
        end
    end

    // Serial output and sticky underrun flag
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            nBOUT    <= 1'b1;
            UNDERRUN <= 1'b0;
        end else begin
            nBOUT <= !(active && (cyc_q != INVALID_CYC) && !wrap_pend && tick_out && shift_q[0]);
            if (ACCTYPE == 3'b000)
                UNDERRUN <= 1'b0;
            else if (underrun_evt)
                UNDERRUN <= 1'b1;
        end
    end

`ifdef BOUT_UNDERRUN_CNT_EN
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST)
            UNDERRUN_CNT <= '0;
        else if (ACCTYPE == 3'b000)
            UNDERRUN_CNT <= '0;
        else if (underrun_evt && (UNDERRUN_CNT != 8'hFF))
            UNDERRUN_CNT <= UNDERRUN_CNT + 8'd1;
    end
`endif

endmodule

// File: tb/tb_bubble_output_serializer.sv
// -----------------------------------------------------------------------------
// tb_bubble_output_serializer
//
// Self-checking bench for bubble_output_serializer. A buffer model answers
// read requests after a fixed delay and logs the requested addresses. Bit
// slots are played from tables of {cycle number, expected bit} records.
// Abort and async reset are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_bubble_output_serializer;

    localparam logic [12:0] INV = 13'h1FFF;
    localparam int          TPH = 16;      // MCLKs per quarter-cycle tick
    localparam int          ACK_DLY = 2;

    typedef struct {
        logic [12:0] cyc;
        logic        exp_bit;
    } vec_t;

    logic        mclk, rst;
    logic [2:0]  acctype;
    logic [12:0] boutcyclenum;
    logic [1:0]  boutticks;
    logic        mem_rd_req;
    logic [10:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_ack;
    logic        nbout;
    logic        underrun;
`ifdef BOUT_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  mem [0:2047];
    logic [10:0] addr_log [$];
    logic        hold_ack = 1'b0;
    int          ack_wait = 0;

    vec_t boot_tbl [12];
    vec_t page_tbl [16];
    vec_t urun_tbl [16];

    bubble_output_serializer dut (
        .MCLK         (mclk),
        .RST          (rst),
        .ACCTYPE      (acctype),
        .BOUTCYCLENUM (boutcyclenum),
        .BOUTTICKS    (boutticks),
        .MEM_RD_REQ   (mem_rd_req),
        .MEM_ADDR     (mem_addr),
        .MEM_DIN      (mem_din),
        .MEM_ACK      (mem_ack),
        .nBOUT        (nbout),
        .UNDERRUN     (underrun)
`ifdef BOUT_UNDERRUN_CNT_EN
        ,
        .UNDERRUN_CNT (underrun_cnt)
`endif
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Buffer model: acknowledges ACK_DLY cycles after a request is seen
    initial begin
        mem_ack = 1'b0;
        mem_din = 8'h00;
        forever begin
            @(negedge mclk);
            mem_ack = 1'b0;
            if (mem_rd_req && !hold_ack) begin
                if (ack_wait >= ACK_DLY - 1) begin
                    mem_ack = 1'b1;
                    mem_din = mem[mem_addr];
                    addr_log.push_back(mem_addr);
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // One bubble cycle: four ticks of TPH MCLKs, nBOUT sampled at the end of each
    task automatic run_slot(input vec_t v);
        for (int ph = 0; ph < 4; ph++) begin
            @(negedge mclk);
            if (ph == 0) boutcyclenum = v.cyc;
            boutticks = ph[1:0];
            idle_cycles(TPH - 1);
            check($sformatf("nbout cyc%0d tick%0d", v.cyc, ph), nbout,
                  (ph == 1 || ph == 2) ? !v.exp_bit : 1'b1);
        end
    endtask

    task automatic wait_req(input logic val, input int max_cyc, input string name);
        int n = 0;
        while (mem_rd_req !== val && n < max_cyc) begin
            @(negedge mclk);
            n++;
        end
        check(name, mem_rd_req, val);
    endtask

    task automatic go_quiet();
        @(negedge mclk);
        boutcyclenum = INV;
        boutticks    = 2'b00;
        acctype      = 3'b000;
        idle_cycles(10);
        addr_log.delete();
    endtask

    initial begin
        // A5 LSB-first, then 3C, then the wrap back to 0 replays A5
        boot_tbl = '{'{13'd0, 1'b1}, '{13'd1, 1'b0}, '{13'd2, 1'b1}, '{13'd3, 1'b0},
                     '{13'd4, 1'b0}, '{13'd5, 1'b1}, '{13'd6, 1'b0}, '{13'd7, 1'b1},
                     '{13'd8, 1'b0}, '{13'd4105, 1'b0}, '{13'd0, 1'b1}, '{13'd1, 1'b0}};
        // FF then 01
        page_tbl = '{'{13'd0, 1'b1}, '{13'd1, 1'b1}, '{13'd2, 1'b1}, '{13'd3, 1'b1},
                     '{13'd4, 1'b1}, '{13'd5, 1'b1}, '{13'd6, 1'b1}, '{13'd7, 1'b1},
                     '{13'd8, 1'b1}, '{13'd9, 1'b0}, '{13'd10, 1'b0}, '{13'd11, 1'b0},
                     '{13'd12, 1'b0}, '{13'd13, 1'b0}, '{13'd14, 1'b0}, '{13'd15, 1'b0}};
        // FF then an underrun byte of zeros
        urun_tbl = '{'{13'd0, 1'b1}, '{13'd1, 1'b1}, '{13'd2, 1'b1}, '{13'd3, 1'b1},
                     '{13'd4, 1'b1}, '{13'd5, 1'b1}, '{13'd6, 1'b1}, '{13'd7, 1'b1},
                     '{13'd8, 1'b0}, '{13'd9, 1'b0}, '{13'd10, 1'b0}, '{13'd11, 1'b0},
                     '{13'd12, 1'b0}, '{13'd13, 1'b0}, '{13'd14, 1'b0}, '{13'd15, 1'b0}};

        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        rst          = 1'b0;
        acctype      = 3'b000;
        boutcyclenum = INV;
        boutticks    = 2'b00;

        // ---- reset state
        #2 rst = 1'b1;
        #1;
        check("rst nbout", nbout, 1'b1);
        check("rst req", mem_rd_req, 1'b0);
        check("rst addr", mem_addr, 11'h000);
        check("rst underrun", underrun, 1'b0);
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(3);

        // ---- bootloader stream with loop wrap
        mem[11'h400] = 8'hA5;
        mem[11'h401] = 8'h3C;
        mem[11'h402] = 8'h0F;
        acctype = 3'b001;
        idle_cycles(4);
        check("stby no req", mem_rd_req, 1'b0);
        acctype = 3'b110;
        idle_cycles(20);
        for (int i = 0; i < 12; i++) run_slot(boot_tbl[i]);
        check("boot addr count", addr_log.size(), 5);
        if (addr_log.size() >= 4) begin
            check("boot addr0", addr_log[0], 11'h400);
            check("boot addr1", addr_log[1], 11'h401);
            check("boot addr2", addr_log[2], 11'h402);
            check("boot refetch addr", addr_log[3], 11'h400);
        end
        check("boot underrun", underrun, 1'b0);

        // ---- user page stream
        go_quiet();
        mem[0] = 8'hFF;
        mem[1] = 8'h01;
        mem[2] = 8'h00;
        acctype = 3'b111;
        idle_cycles(20);
        for (int i = 0; i < 16; i++) run_slot(page_tbl[i]);
        check("page addr count", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            check("page addr0", addr_log[0], 11'h000);
            check("page addr1", addr_log[1], 11'h001);
            check("page addr2", addr_log[2], 11'h002);
        end

        // ---- underrun: ACK withheld past the slot-8 byte boundary
        go_quiet();
        check("underrun clear before", underrun, 1'b0);
        acctype = 3'b111;
        idle_cycles(20);
        hold_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            run_slot(urun_tbl[i]);
            if (i == 7) check("underrun before slot8", underrun, 1'b0);
            if (i == 8) begin
                check("underrun at slot8", underrun, 1'b1);
                hold_ack = 1'b0;
            end
        end
        check("urun addr count", addr_log.size(), 2);
        if (addr_log.size() == 2) check("urun late addr", addr_log[1], 11'h001);
        @(negedge mclk);
        boutcyclenum = INV;
        acctype = 3'b100;
        idle_cycles(5);
        check("underrun sticky idle", underrun, 1'b1);
`ifdef BOUT_UNDERRUN_CNT_EN
        check("underrun cnt", underrun_cnt, 8'd1);
`endif
        acctype = 3'b000;
        idle_cycles(2);
        check("underrun cleared", underrun, 1'b0);
`ifdef BOUT_UNDERRUN_CNT_EN
        check("underrun cnt cleared", underrun_cnt, 8'd0);
`endif

        // ---- abort while a read is outstanding
        go_quiet();
        mem[0] = 8'h00;
        hold_ack = 1'b1;
        acctype = 3'b111;
        idle_cycles(4);
        check("abort req up", mem_rd_req, 1'b1);
        check("abort req addr", mem_addr, 11'h000);
        acctype = 3'b100;
        idle_cycles(4);
        check("abort req held", mem_rd_req, 1'b1);
        hold_ack = 1'b0;
        wait_req(1'b0, 20, "abort req dropped");
        idle_cycles(4);
        check("abort stays idle", mem_rd_req, 1'b0);
        check("abort nbout", nbout, 1'b1);
        mem[0] = 8'h81;
        addr_log.delete();
        acctype = 3'b111;
        idle_cycles(20);
        check("restart addr count", addr_log.size(), 1);
        if (addr_log.size() == 1) check("restart addr", addr_log[0], 11'h000);
        // Bit 0 of 0x81 drives nBOUT low; leaving Active raises it one cycle later.
        boutcyclenum = 13'd0;
        boutticks = 2'b00;
        idle_cycles(TPH);
        boutticks = 2'b01;
        idle_cycles(4);
        check("restart bit0", nbout, 1'b0);
        acctype = 3'b100;
        idle_cycles(1);
        check("abort nbout next cycle", nbout, 1'b1);

        // ---- asynchronous reset in the middle of activity
        go_quiet();
        mem[0] = 8'hFF;
        hold_ack = 1'b1;
        acctype = 3'b111;
        idle_cycles(4);
        run_slot('{13'd0, 1'b0});
        check("pre-rst underrun", underrun, 1'b1);
        hold_ack = 1'b0;
        idle_cycles(6);
        hold_ack = 1'b1;
        boutcyclenum = 13'd8;
        boutticks = 2'b00;
        idle_cycles(TPH);
        boutticks = 2'b01;
        idle_cycles(4);
        check("pre-rst nbout", nbout, 1'b0);
        check("pre-rst req", mem_rd_req, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("async rst nbout", nbout, 1'b1);
        check("async rst req", mem_rd_req, 1'b0);
        check("async rst underrun", underrun, 1'b0);
        check("async rst addr", mem_addr, 11'h000);
        idle_cycles(2);
        rst = 1'b0;
        hold_ack = 1'b0;
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
